// File: rtl/aes128_inv_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_inv_core
//  Description : Iterative AES-128 inverse cipher (FIPS-197). One inverse
//                round per clock. Round keys are never stored: the key is
//                first expanded forward to round key 10. It is then rolled
//                back one step per round while the block is decrypted.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1    clock
//    rst_n          in   1    asynchronous reset, active-low
//    start_i        in   1    request, accepted on a posedge while ready_o=1
//    key_i          in   128  cipher key, sampled with start_i
//    cipher_text_i  in   128  ciphertext block, sampled with start_i
//    plain_text_o   out  128  plaintext, held until the next completion
//    ready_o        out  1    core idle
//    done_o         out  1    single-cycle completion pulse
//  Byte 0 is bits [127:120]. Column c holds bytes 4c..4c+3.
// ============================================================================
module aes128_inv_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] cipher_text_i,
    output logic [127:0] plain_text_o,
    output logic         ready_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ADDKEY = 2'd2,
        ROUND  = 2'd3
    } fsm_t;

    fsm_t         fsm;
    logic [127:0] rk_reg;     // current round key (forward, then reverse walk)
    logic [127:0] state_reg;  // cipher state
    logic [3:0]   cnt;        // forward expansion step counter
    logic [3:0]   rnd;        // inverse round index, 9 down to 0
    logic [7:0]   rcon;

    // ------------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11B
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Undoes xtime, which walks rcon backwards through the schedule.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        inv_xtime = {1'b0, b[7:1]} ^ (b[0] ? 8'h8d : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        gf_mul = acc;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        gf_inv = acc;
    endfunction

    // ------------------------------------------------------------------------
    // S-boxes: field inverse plus the FIPS-197 affine map (and its inverse)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x    = gf_inv(a);
        sbox = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] x;
        x        = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        inv_sbox = gf_inv(x);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        sub_rot_word = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        inv_mix_col = {
            gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)
        };
    endfunction

    // ------------------------------------------------------------------------
    // Key schedule: one forward step and one reverse step share a single
    // SubWord(RotWord()) unit. Forward feeds it w3 of the current key. Reverse
    // feeds it the recovered w3 of the previous key, which is w3' ^ w2'.
    // ------------------------------------------------------------------------
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [31:0]  rev_w1, rev_w2, rev_w3;
    logic [31:0]  sub_in, sub_out, rcon_word;
    logic [31:0]  fwd_w0, fwd_w1, fwd_w2, fwd_w3;
    logic [127:0] rk_fwd, rk_rev;

    assign kw0 = rk_reg[127:96];
    assign kw1 = rk_reg[95:64];
    assign kw2 = rk_reg[63:32];
    assign kw3 = rk_reg[31:0];

    assign rev_w3 = kw3 ^ kw2;
    assign rev_w2 = kw2 ^ kw1;
    assign rev_w1 = kw1 ^ kw0;

    assign sub_in    = (fsm == KEYEXP) ? kw3 : rev_w3;
    assign sub_out   = sub_rot_word(sub_in);
    assign rcon_word = {rcon, 24'h000000};

    assign fwd_w0 = kw0 ^ sub_out ^ rcon_word;
    assign fwd_w1 = kw1 ^ fwd_w0;
    assign fwd_w2 = kw2 ^ fwd_w1;
    assign fwd_w3 = kw3 ^ fwd_w2;

    assign rk_fwd = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
    assign rk_rev = {kw0 ^ sub_out ^ rcon_word, rev_w1, rev_w2, rev_w3};

    // ------------------------------------------------------------------------
    // Inverse round datapath. InvShiftRows is pure wiring: row r of column c
    // takes row r of column (c - r) mod 4.
    // ------------------------------------------------------------------------
    logic [127:0] isb;   // InvSubBytes(InvShiftRows(state))
    logic [127:0] ark;   // ... ^ round key
    logic [127:0] imc;   // InvMixColumns(...)

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int BYTE_IDX = 4 * c + r;
            localparam int SRC_IDX  = 4 * ((c + 4 - r) % 4) + r;
            assign isb[127 - 8 * BYTE_IDX -: 8] = inv_sbox(state_reg[127 - 8 * SRC_IDX -: 8]);
        end
        assign ark[127 - 32 * c -: 32] = isb[127 - 32 * c -: 32] ^ rk_rev[127 - 32 * c -: 32];
        assign imc[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
    end

    assign ready_o = (fsm == IDLE);

    // ------------------------------------------------------------------------
    // Control and state registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm          <= IDLE;
            rk_reg       <= '0;
            state_reg    <= '0;
            cnt          <= '0;
            rnd          <= '0;
            rcon         <= '0;
            plain_text_o <= '0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        rk_reg    <= key_i;
                        state_reg <= cipher_text_i;
                        cnt       <= 4'd1;
                        rcon      <= 8'h01;
                        fsm       <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    rk_reg <= rk_fwd;
                    cnt    <= cnt + 4'd1;
                    // The last forward step keeps rcon at 0x36. That value is
                    // exactly what the first reverse step needs.
                    if (cnt == 4'd10) begin
                        fsm <= ADDKEY;
                    end else begin
                        rcon <= xtime(rcon);
                    end
                end
                ADDKEY: begin
                    state_reg <= state_reg ^ rk_reg;
                    rnd       <= 4'd9;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    rk_reg <= rk_rev;
                    rcon   <= inv_xtime(rcon);
                    rnd    <= rnd - 4'd1;
                    if (rnd == 4'd0) begin
                        plain_text_o <= ark;
                        done_o       <= 1'b1;
                        fsm          <= IDLE;
                    end else begin
                        state_reg <= imc;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/aes128_inv_core.md
Name: aes128_inv_core

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher); the receive-side counterpart to aes128_core, with the same start/ready/done handshake.
- Accepts a 128-bit cipher key and ciphertext block and returns the plaintext after a fixed latency, processing one inverse round per clock.
- Round keys are not stored. The core expands the key forward to round key 10, then regresses it one step per round during decryption.
- Sits beside aes128_core in the crypto accelerator datapath.

Parameters:
- None. Key size is fixed at 128 bits and Nr = 10.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- start_i  input  1  request; sampled at posedge only when ready_o=1
- key_i  input  128  cipher key (same key as used for encryption); sampled with start_i
- cipher_text_i  input  128  ciphertext block; sampled with start_i
- plain_text_o  output  128  decrypted block; valid from the done_o cycle until the next result
- ready_o  output  1  core idle, can accept start_i
- done_o  output  1  single-cycle completion pulse

Behaviour:
- Byte order: bits [127:120] are byte 0 (first byte of the FIPS hex string). State is column-major, so column c = bytes 4c..4c+3.
- Reset (async, immediate): FSM=IDLE, plain_text_o=0, done_o=0, ready_o=1, all internal key, state and counter registers = 0.
- FSM states: IDLE, KEYEXP, ADDKEY, ROUND.
- ready_o = (FSM==IDLE), combinational from state.
- Edge numbering: E0 is the posedge where start_i=1 and ready_o=1.
- IDLE, at E0: latch key_i into rk_reg, latch cipher_text_i, cnt=1, rcon=0x01, go to KEYEXP. If start_i=0, stay in IDLE.
- KEYEXP, edges E1..E10: rk_reg <= forward expansion step.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - wi' = wi ^ w(i-1)' for i = 1..3
  - rcon <= xtime(rcon); cnt++
  - After E10, rk_reg = round key 10 and rcon = 0x36. Go to ADDKEY.
- ADDKEY, edge E11: state <= ciphertext ^ rk10. Go to ROUND with rnd=9.
- ROUND, edges E12..E21, one inverse round per edge for rnd = 9 down to 0:
  - The combinational reverse key step derives rk_rnd from rk_reg:
    - w3 = w3' ^ w2'
    - w2 = w2' ^ w1'
    - w1 = w1' ^ w0'
    - w0 = w0' ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - Register updates: rk_reg <= rk_rnd; rcon <= inverse xtime(rcon).
  - Inverse xtime: if the LSB is set, shift right and XOR 0x8D; otherwise shift right.
  - Datapath, rnd 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_rnd).
  - Datapath, rnd 0: plain_text_o <= InvSubBytes(InvShiftRows(state)) ^ rk0, with no InvMixColumns. done_o <= 1 and FSM goes to IDLE.
- Latency: done_o is high for exactly one cycle, between E21 and E22.
- Output hold: plain_text_o holds its value until the next completion. It does not change on the next start.
- Back-to-back operation: ready_o=1 during the done_o cycle, so a start_i held high there is accepted at E22.
- start_i while busy (ready_o=0) is ignored and has no effect on the operation in flight.
- Changes to key_i or cipher_text_i after E0 have no effect.
- Reset asserted mid-operation aborts the operation. done_o is never asserted for the aborted block, and outputs return to their reset values.
- S-box and inverse S-box are combinational lookup functions inside the module.
- Datapath logic instances: 4 forward S-boxes for the key step, 16 inverse S-boxes for the datapath, and 4 InvMixColumns column units.
- GF(2^8) polynomial 0x11B; InvMixColumns coefficients {0e,0b,0d,09}.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text_o = 00112233445566778899aabbccddeeff. done_o is high 21 cycles after E0 for exactly 1 cycle.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Round-trip with the encrypt core: key 2b7e151628aed2a6abf7158809cf4f3c, ct 8df4e9aac5c7573a27d8d055d6e4d64b -> 00112233445566778899aabbccddeeff.
- Back-to-back: hold start_i=1 during the done_o cycle with the C.1 vector, then the App. B vector -> second done_o exactly 22 cycles after the first, with correct results for both. start_i pulsed at E5 while busy -> ignored, no extra done_o.
- Reset mid-operation: deassert rst_n at E8 for 2 cycles -> plain_text_o=0, done_o stays 0, ready_o=1. A fresh C.1 start afterwards completes correctly.
- Input stability: change key_i and cipher_text_i to random values at E1 -> result is still the C.1 plaintext.
